// File: rtl/k6502_bus_resp_pkg.sv
// Shared decode constants and FSM state type for the k6502 bus responder.
package k6502_bus_resp_pkg;

    localparam logic [2:0] RamRegion = 3'b000;
    localparam logic [2:0] ExtRegion = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StExtWait,
        StExtDone
    } br_state_e;

endpackage

// File: rtl/k6502_bus_resp_if.sv
// CPU-cycle and external req/ack signals seen by the k6502 bus responder.
interface k6502_bus_resp_if;

    logic [15:0] a;
    logic        rw;
    logic [7:0]  cpu_do;
    logic        sync;
    logic [7:0]  d;
    logic        rdy;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    modport slave (
        input  a, rw, cpu_do, sync, ext_rdata, ext_ack,
        output d, rdy, ext_req, ext_we, ext_addr, ext_wdata
    );

    modport master (
        output a, rw, cpu_do, sync, ext_rdata, ext_ack,
        input  d, rdy, ext_req, ext_we, ext_addr, ext_wdata
    );

endinterface

// File: rtl/k6502_bus_resp_ram.sv
// Internal byte RAM: asynchronous read, synchronous write, contents never reset.
module k6502_bus_resp_ram #(
    parameter int unsigned AddrW = 11
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [0:(1 << AddrW) - 1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/k6502_bus_resp.sv
// k6502 bus responder: mirrored internal RAM, held external window, open-bus reads,
// opcode-fetch counting.
module k6502_bus_resp
    import k6502_bus_resp_pkg::*;
#(
    parameter int unsigned RamAw   = 11,
    parameter int unsigned Timeout = 16,
    parameter logic [7:0]  TmoData = 8'hFF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    k6502_bus_resp_if.slave    bus,
    output logic [15:0]        fetch_cnt_o,
    output logic               timeout_err_o
);

    localparam int unsigned     TmoW    = (Timeout > 2) ? $clog2(Timeout) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(Timeout - 1);

    br_state_e       state_q, state_d;
    logic            ram_hit, ext_hit, ram_we, tmo_hit;
    logic            rdy;
    logic [7:0]      d_out, ram_rdata;
    logic [7:0]      rdata_q, openbus_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            ext_req_q, ext_we_q;
    logic [15:0]     ext_addr_q;
    logic [7:0]      ext_wdata_q;
    logic [15:0]     fetch_cnt_q;
    logic            timeout_err_q;

    assign ram_hit = (bus.a[15:13] == RamRegion);
    assign ext_hit = (bus.a[15:13] == ExtRegion);
    assign tmo_hit = (tmo_cnt_q == TmoLast);
    assign ram_we  = rst_ni & ~bus.rw & rdy & ram_hit;

    k6502_bus_resp_ram #(
        .AddrW (RamAw)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (bus.a[RamAw-1:0]),
        .wdata_i (bus.cpu_do),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (ext_hit) state_d = StExtWait;
            StExtWait: if (bus.ext_ack || tmo_hit) state_d = StExtDone;
            StExtDone: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Reset forces a released bus so the CPU sees rdy=1, d=0 regardless of state.
    always_comb begin
        rdy   = 1'b1;
        d_out = openbus_q;
        if (!rst_ni) begin
            d_out = 8'h00;
        end else begin
            case (state_q)
                StIdle: begin
                    rdy = ~ext_hit;
                    if (ram_hit) d_out = ram_rdata;
                end
                StExtWait: rdy = 1'b0;
                StExtDone: d_out = rdata_q;
                default:   rdy = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ext_req_q     <= 1'b0;
            ext_we_q      <= 1'b0;
            ext_addr_q    <= 16'h0000;
            ext_wdata_q   <= 8'h00;
            tmo_cnt_q     <= '0;
            rdata_q       <= 8'h00;
            openbus_q     <= 8'h00;
            fetch_cnt_q   <= 16'h0000;
            timeout_err_q <= 1'b0;
        end else begin
            if (rdy) openbus_q <= bus.rw ? d_out : bus.cpu_do;
            if (rdy && bus.sync) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            case (state_q)
                StIdle: begin
                    if (ext_hit) begin
                        ext_req_q   <= 1'b1;
                        ext_we_q    <= ~bus.rw;
                        ext_addr_q  <= bus.a;
                        ext_wdata_q <= bus.cpu_do;
                        tmo_cnt_q   <= '0;
                    end
                end
                StExtWait: begin
                    if (bus.ext_ack) begin
                        rdata_q   <= bus.ext_rdata;
                        ext_req_q <= 1'b0;
                        ext_we_q  <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (tmo_hit) begin
                            rdata_q       <= TmoData;
                            timeout_err_q <= 1'b1;
                            ext_req_q     <= 1'b0;
                            ext_we_q      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy       = rdy;
    assign bus.d         = d_out;
    assign bus.ext_req   = ext_req_q;
    assign bus.ext_we    = ext_we_q;
    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign fetch_cnt_o   = fetch_cnt_q;
    assign timeout_err_o = timeout_err_q;

endmodule
